axis_read_address: RTL and testbench
====================================

Name: axis_read_address

Overview:
- AXI read-address-channel stage, sitting directly upstream of the read data channel stage in the stream-read engine.
- Accepts one stream command (byte start address, length in DATA_WIDTH words) and converts it into a sequence of AXI INCR bursts on the AR channel.
- Each burst is capped at BURST_MAX beats and never crosses a 4 KB boundary.
- The data stage is configured with the same length in parallel and consumes the resulting R beats.

Parameters:
- CONFIG_AWIDTH, 32, width of cfg_address
- CONFIG_DWIDTH, 32, width of cfg_length
- WIDTH_RATIO, 2, AXI_DATA_WIDTH/DATA_WIDTH; power of two, at least 1
- AXI_ADDR_WIDTH, 32, width of axi_araddr
- AXI_DATA_WIDTH, 64, AXI data width; sets bytes per beat (BPB = AXI_DATA_WIDTH/8)
- AXI_LEN_WIDTH, 8, width of axi_arlen
- BURST_MAX, 16, maximum beats per burst; power of two, at most 2^AXI_LEN_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_address  in  CONFIG_AWIDTH  byte start address; low log2(BPB) bits ignored (treated as 0)
- cfg_length  in  CONFIG_DWIDTH  stream length in DATA_WIDTH words
- cfg_valid  in  1  command valid
- cfg_ready  out  1  high only in IDLE
- axi_araddr  out  AXI_ADDR_WIDTH  burst start address
- axi_arlen  out  AXI_LEN_WIDTH  beats-1
- axi_arsize  out  3  constant log2(BPB)
- axi_arburst  out  2  constant 2'b01 (INCR)
- axi_arvalid  out  1  address valid
- axi_arready  in  1  address ready
- done  out  1  one-cycle pulse when the command has been fully issued

Behaviour:
- Reset values: state IDLE, axi_arvalid=0, done=0, cfg_ready=1. axi_araddr and axi_arlen have don't-care reset values.
- Command accept: on cfg_valid & cfg_ready, register the following:
  - addr = cfg_address with low bits cleared
  - beats = ceil(cfg_length/WIDTH_RATIO), computed as (cfg_length + WIDTH_RATIO-1) >> log2(WIDTH_RATIO)
  - beats is CONFIG_DWIDTH+1 bits wide, so no overflow occurs
- State machine, one-hot with states IDLE, SETUP, ACTIVE, DONE:
  - IDLE -> SETUP on accept; otherwise stay in IDLE.
  - SETUP: if beats==0, go to DONE. Otherwise compute the burst and go to ACTIVE:
    - burst = min(beats, BURST_MAX, b4k), where b4k = (4096 - addr[11:0]) / BPB
    - register axi_araddr = addr and axi_arlen = burst-1
  - ACTIVE: axi_arvalid=1. On axi_arready, do addr += burst*BPB and beats -= burst. Then:
    - if beats-burst == 0, go to DONE
    - otherwise go back to SETUP
  - DONE: done=1 for this one cycle, then go to IDLE.
- Latency:
  - Accept in cycle N gives first axi_arvalid in cycle N+2.
  - Between consecutive bursts there is exactly one cycle with axi_arvalid=0 (the SETUP cycle).
  - The last handshake in cycle M gives done=1 in cycle M+1 and cfg_ready=1 in cycle M+2.
- AXI rule: once axi_arvalid is asserted, axi_araddr, axi_arlen and axi_arvalid stay stable until axi_arready is sampled high.
- Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH. Wrap is not checked; software must avoid it.
- cfg_valid is ignored outside IDLE, and cfg_* need not be held after the accept.
- cfg_length=0: no AR transaction is issued; the sequence is IDLE -> SETUP -> DONE (done pulse) -> IDLE.
- b4k is always at least 1, because the address is BPB-aligned.
- Reset mid-operation:
  - next cycle: IDLE, axi_arvalid=0, done=0
  - an outstanding burst is abandoned; the system must also reset the downstream data stage

Decomposition:
- Shared package/header:
  - state indices IDLE/SETUP/ACTIVE/DONE
  - AXI_BURST_INCR = 2'b01
  - AXI_4K_BYTES = 4096
  - a clog2 helper for arsize and WIDTH_RATIO shift
- No sub-module. Burst-size selection is a small combinational min() inside the block, about 200 lines total.

Test Plan:
- addr 0x1000_0000, len 32 (WIDTH_RATIO 2, BPB 8) -> one burst: araddr 0x1000_0000, arlen 15; done one cycle after the handshake.
- addr 0x2000_0000, len 70 (35 beats) -> three bursts: araddr 0x2000_0000/0x2000_0080/0x2000_0100 with arlen 15/15/2; one idle cycle between bursts.
- 4 KB crossing: addr 0x0000_0FC0, len 32 (16 beats) -> araddr 0x0FC0 arlen 7, then araddr 0x1000 arlen 7.
- Odd length: addr 0x0, len 5 -> 3 beats, single burst with arlen 2. len 0 -> no arvalid, done 2 cycles after accept, cfg_ready 1 the cycle after.
- Backpressure: hold arready=0 for 10 cycles during a burst -> arvalid stays 1 and araddr/arlen stay constant. cfg_valid pulsed during ACTIVE is ignored (cfg_ready=0).
- Reset mid-ACTIVE (arready=0) -> next cycle arvalid=0 and cfg_ready=1. A new command with addr 0x3000_0000, len 16 then issues araddr 0x3000_0000, arlen 7.

Source files
------------

// File: rtl/axis_read_address_pkg.sv
// Shared definitions for the stream-read AR stage: one-hot state indices,
// AXI burst constants and a constant-time log2 helper.
package axis_read_address_pkg;

  localparam int NUM_STATES = 4;
  localparam int S_IDLE     = 0;
  localparam int S_SETUP    = 1;
  localparam int S_ACTIVE   = 2;
  localparam int S_DONE     = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         AXI_4K_BYTES   = 4096;

  // Ceiling log2; only ever evaluated on parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_read_address.sv
// Splits one stream command into AXI INCR read bursts, capped at BURST_MAX beats
// and never crossing a 4 KB page. First ARVALID two cycles after accept.
module axis_read_address
  import axis_read_address_pkg::*;
#(
  parameter int CONFIG_AWIDTH  = 32,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int BURST_MAX      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_AWIDTH-1:0]  cfg_address,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic                      done
);

  localparam int BPB         = AXI_DATA_WIDTH / 8;
  localparam int BPB_SHIFT   = clog2(BPB);
  localparam int RATIO_SHIFT = clog2(WIDTH_RATIO);
  localparam int BEATS_W     = CONFIG_DWIDTH + 1;
  // Wide enough for any burst count up to a full 4 KB page of single-byte beats.
  localparam int BURST_W     = 13;

  logic [NUM_STATES-1:0]     state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [BEATS_W-1:0]        beats_q;
  logic [BURST_W-1:0]        burst_q;
  logic [BURST_W-1:0]        b4k, cap, burst_sel;
  logic                      accept, ar_hs, last_burst;

  assign accept     = state_q[S_IDLE] & cfg_valid;
  assign ar_hs      = state_q[S_ACTIVE] & axi_arready;
  assign last_burst = (beats_q == BEATS_W'(burst_q));

  // Beats left before the next 4 KB page; never zero since addr_q is BPB-aligned.
  assign b4k       = (BURST_W'(AXI_4K_BYTES) - BURST_W'(addr_q[11:0])) >> BPB_SHIFT;
  assign cap       = (b4k < BURST_W'(BURST_MAX)) ? b4k : BURST_W'(BURST_MAX);
  assign burst_sel = (beats_q < BEATS_W'(cap)) ? BURST_W'(beats_q) : cap;

  assign axi_arsize  = 3'(BPB_SHIFT);
  assign axi_arburst = AXI_BURST_INCR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= '0;
      state_q[S_IDLE] <= 1'b1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = '0;
    case (1'b1)
      state_q[S_IDLE]:   state_d[accept ? S_SETUP : S_IDLE] = 1'b1;
      state_q[S_SETUP]:  state_d[(beats_q == '0) ? S_DONE : S_ACTIVE] = 1'b1;
      state_q[S_ACTIVE]: state_d[ar_hs ? (last_burst ? S_DONE : S_SETUP) : S_ACTIVE] = 1'b1;
      state_q[S_DONE]:   state_d[S_IDLE] = 1'b1;
      default:           state_d[S_IDLE] = 1'b1;
    endcase
  end

  always_comb begin
    cfg_ready   = state_q[S_IDLE];
    axi_arvalid = state_q[S_ACTIVE];
    done        = state_q[S_DONE];
  end

  // AR payload only changes in SETUP, so it is stable for the whole ACTIVE phase.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BPB - 1);
      beats_q <= (BEATS_W'(cfg_length) + BEATS_W'(WIDTH_RATIO - 1)) >> RATIO_SHIFT;
    end else if (ar_hs) begin
      addr_q  <= addr_q + (AXI_ADDR_WIDTH'(burst_q) << BPB_SHIFT);
      beats_q <= beats_q - BEATS_W'(burst_q);
    end
    if (state_q[S_SETUP]) begin
      burst_q    <= burst_sel;
      axi_araddr <= addr_q;
      axi_arlen  <= AXI_LEN_WIDTH'(burst_sel - 1'b1);
    end
  end

endmodule

// File: tb/tb_axis_read_address.sv
// Directed bench for axis_read_address: burst splitting, 4 KB crossing,
// zero length, backpressure, ignored commands and mid-burst reset.
module tb_axis_read_address;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] got_addr[$];
  logic [7:0]  got_len[$];
  int          hs_cyc[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  int          first_cyc;
  int          done_cyc;

  axis_read_address dut (
    .clk(clk), .rst(rst),
    .cfg_address(cfg_address), .cfg_length(cfg_length),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] l, output int acc);
    cfg_address = a;
    cfg_length  = l;
    cfg_valid   = 1'b1;
    acc         = cyc;
    check("cfg_ready_at_issue", 64'(cfg_ready), 64'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic collect(input string name, input int budget);
    got_addr.delete();
    got_len.delete();
    hs_cyc.delete();
    first_cyc = -1;
    done_cyc  = -1;
    for (int i = 0; i < budget; i++) begin
      if (axi_arvalid && first_cyc < 0) first_cyc = cyc;
      if (axi_arvalid && axi_arready) begin
        got_addr.push_back(axi_araddr);
        got_len.push_back(axi_arlen);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      step();
    end
    check({name, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    if (done_cyc >= 0) begin
      step();
      check({name, "_done_width"}, 64'(done), 64'd0);
      check({name, "_cfg_ready_after"}, 64'(cfg_ready), 64'd1);
    end
  endtask

  task automatic verify(input string name, input int acc, input bit timing);
    int n;
    n = got_addr.size();
    check({name, "_nbursts"}, 64'(n), 64'(exp_addr.size()));
    if (n == exp_addr.size()) begin
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_araddr%0d", name, i), 64'(got_addr[i]), 64'(exp_addr[i]));
        check($sformatf("%s_arlen%0d", name, i), 64'(got_len[i]), 64'(exp_len[i]));
        if (i > 0)
          check($sformatf("%s_gap%0d", name, i), 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);
      end
      if (n > 0) begin
        if (timing) check({name, "_first_arvalid"}, 64'(first_cyc), 64'(acc + 2));
        check({name, "_done_cycle"}, 64'(done_cyc), 64'(hs_cyc[n-1] + 1));
      end else begin
        check({name, "_done_cycle"}, 64'(done_cyc), 64'(acc + 2));
        check({name, "_no_arvalid"}, 64'(first_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  endtask

  initial begin
    int          acc;
    bit          stable;
    bit          quiet;
    logic [31:0] cap_addr;
    logic [7:0]  cap_len;

    rst         = 1'b1;
    cfg_address = '0;
    cfg_length  = '0;
    cfg_valid   = 1'b0;
    axi_arready = 1'b1;
    repeat (3) step();
    check("rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("arsize", 64'(axi_arsize), 64'd3);
    check("arburst", 64'(axi_arburst), 64'd1);
    rst = 1'b0;
    step();

    issue(32'h1000_0000, 32'd32, acc);
    collect("single", 100);
    exp_addr = '{32'h1000_0000};
    exp_len  = '{8'd15};
    verify("single", acc, 1'b1);

    issue(32'h2000_0000, 32'd70, acc);
    collect("multi", 100);
    exp_addr = '{32'h2000_0000, 32'h2000_0080, 32'h2000_0100};
    exp_len  = '{8'd15, 8'd15, 8'd2};
    verify("multi", acc, 1'b1);

    issue(32'h0000_0FC0, 32'd32, acc);
    collect("cross4k", 100);
    exp_addr = '{32'h0000_0FC0, 32'h0000_1000};
    exp_len  = '{8'd7, 8'd7};
    verify("cross4k", acc, 1'b1);

    issue(32'h0000_0000, 32'd5, acc);
    collect("odd", 100);
    exp_addr = '{32'h0000_0000};
    exp_len  = '{8'd2};
    verify("odd", acc, 1'b1);

    issue(32'h0000_0105, 32'd2, acc);
    collect("unaligned", 100);
    exp_addr = '{32'h0000_0100};
    exp_len  = '{8'd0};
    verify("unaligned", acc, 1'b1);

    issue(32'h0000_8000, 32'd0, acc);
    collect("zero", 100);
    exp_addr.delete();
    exp_len.delete();
    verify("zero", acc, 1'b1);

    // Backpressure: payload must hold while ARREADY is low; a command offered meanwhile is dropped.
    axi_arready = 1'b0;
    issue(32'h4000_0000, 32'd32, acc);
    for (int i = 0; i < 10 && !axi_arvalid; i++) step();
    check("bp_arvalid", 64'(axi_arvalid), 64'd1);
    cap_addr = axi_araddr;
    cap_len  = axi_arlen;
    stable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        cfg_address = 32'hDEAD_0000;
        cfg_length  = 32'd8;
        cfg_valid   = 1'b1;
        check("bp_cfg_ready", 64'(cfg_ready), 64'd0);
      end
      step();
      cfg_valid = 1'b0;
      if (!axi_arvalid || axi_araddr !== cap_addr || axi_arlen !== cap_len) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_addr", 64'(cap_addr), 64'h4000_0000);
    check("bp_len", 64'(cap_len), 64'd15);
    axi_arready = 1'b1;
    collect("bp", 100);
    exp_addr = '{32'h4000_0000};
    exp_len  = '{8'd15};
    verify("bp", acc, 1'b0);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (axi_arvalid || done) quiet = 1'b0;
      step();
    end
    check("bp_ignored_cmd", 64'(quiet), 64'd1);

    axi_arready = 1'b0;
    issue(32'h5000_0000, 32'd32, acc);
    for (int i = 0; i < 10 && !axi_arvalid; i++) step();
    check("rstmid_arvalid", 64'(axi_arvalid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_arvalid_low", 64'(axi_arvalid), 64'd0);
    check("rstmid_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rstmid_done", 64'(done), 64'd0);
    axi_arready = 1'b1;
    issue(32'h3000_0000, 32'd16, acc);
    collect("after_rst", 100);
    exp_addr = '{32'h3000_0000};
    exp_len  = '{8'd7};
    verify("after_rst", acc, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
